// File: rtl/logging_bram_arbiter.sv
// Arbitrates a logger write port and a Wishbone read window onto one blockram master.
// Writes append at wr_ptr as a ring buffer, or drop once full; every bram access is bounded by a timeout.
module logging_bram_arbiter #(
    parameter int DEPTH        = 2048,
    parameter bit STOP_ON_FULL = 1'b0,
    parameter int TIMEOUT      = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        log_en_i,
    input  logic        clr_i,
    input  logic        log_req_i,
    input  logic [15:0] log_dat_i,
    output logic        log_ack_o,
    input  logic        rd_wb_cyc_i,
    input  logic        rd_wb_stb_i,
    input  logic [11:0] rd_wb_adr_i,
    output logic [15:0] rd_wb_dat_o,
    output logic        rd_wb_ack_o,
    output logic        bram_wb_cyc_o,
    output logic        bram_wb_stb_o,
    output logic        bram_wb_we_o,
    output logic [11:0] bram_wb_adr_o,
    output logic [15:0] bram_wb_dat_o,
    input  logic [15:0] bram_wb_dat_i,
    input  logic        bram_wb_ack_i,
    output logic [11:0] wr_ptr_o,
    output logic [12:0] count_o,
    output logic [15:0] drop_cnt_o,
    output logic        wrapped_o,
    output logic        err_o
);

    localparam logic [11:0] PTR_LAST = 12'(DEPTH - 1);
    localparam logic [12:0] CNT_FULL = 13'(DEPTH);
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [11:0] adr;
        logic [15:0] dat;
    } bram_req_t;

    state_t    state_q, state_d;
    bram_req_t bram_q, bram_d;
    logic        log_ack_q, log_ack_d;
    logic        rd_ack_q, rd_ack_d;
    logic [15:0] rd_dat_q, rd_dat_d;
    logic [11:0] wr_ptr_q, wr_ptr_d;
    logic [12:0] count_q, count_d;
    logic [15:0] drop_q, drop_d;
    logic        wrapped_q, wrapped_d;
    logic        err_q, err_d;
    logic        last_wr_q, last_wr_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        clr_seen_q, clr_seen_d;

    logic wr_pend, rd_pend, full, tmo_hit;

    // A requester whose ack is still high is presenting the request just served.
    assign wr_pend = log_req_i && log_en_i && !log_ack_q;
    assign rd_pend = rd_wb_cyc_i && rd_wb_stb_i && !rd_ack_q;
    assign full    = STOP_ON_FULL && (count_q == CNT_FULL);
    assign tmo_hit = (tmo_q == TMO_LAST);

    always_comb begin
        state_d    = state_q;
        bram_d     = bram_q;
        log_ack_d  = 1'b0;
        rd_ack_d   = 1'b0;
        rd_dat_d   = rd_dat_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        drop_d     = drop_q;
        wrapped_d  = wrapped_q;
        err_d      = err_q;
        last_wr_d  = last_wr_q;
        tmo_d      = tmo_q;
        clr_seen_d = clr_seen_q;

        case (state_q)
            IDLE: begin
                tmo_d      = 8'd0;
                clr_seen_d = clr_i;
                if (wr_pend && (!rd_pend || !last_wr_q)) begin
                    last_wr_d = 1'b1;
                    if (full) begin
                        log_ack_d = 1'b1;
                        drop_d    = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
                    end else begin
                        state_d = WR;
                        bram_d  = '{cyc: 1'b1, stb: 1'b1, we: 1'b1, adr: wr_ptr_q, dat: log_dat_i};
                    end
                end else if (rd_pend) begin
                    last_wr_d = 1'b0;
                    state_d   = RD;
                    bram_d    = '{cyc: 1'b1, stb: 1'b1, we: 1'b0, adr: rd_wb_adr_i, dat: 16'h0};
                end
            end
            WR: begin
                if (clr_i) clr_seen_d = 1'b1;
                if (bram_wb_ack_i || tmo_hit) begin
                    state_d    = IDLE;
                    bram_d.cyc = 1'b0;
                    bram_d.stb = 1'b0;
                    bram_d.we  = 1'b0;
                    log_ack_d  = 1'b1;
                end
                if (bram_wb_ack_i) begin
                    // A clear seen during the access leaves the pointer at zero.
                    if (!clr_seen_q) begin
                        wr_ptr_d  = (wr_ptr_q == PTR_LAST) ? 12'd0 : wr_ptr_q + 12'd1;
                        wrapped_d = wrapped_q || (wr_ptr_q == PTR_LAST);
                        count_d   = (count_q == CNT_FULL) ? count_q : count_q + 13'd1;
                    end
                end else if (tmo_hit) begin
                    err_d  = 1'b1;
                    drop_d = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            RD: begin
                if (bram_wb_ack_i || tmo_hit) begin
                    state_d    = IDLE;
                    bram_d.cyc = 1'b0;
                    bram_d.stb = 1'b0;
                    rd_ack_d   = 1'b1;
                end
                if (bram_wb_ack_i) begin
                    rd_dat_d = bram_wb_dat_i;
                end else if (tmo_hit) begin
                    rd_dat_d = 16'hDEAD;
                    err_d    = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clr_i) begin
            wr_ptr_d  = 12'd0;
            count_d   = 13'd0;
            wrapped_d = 1'b0;
            err_d     = 1'b0;
            drop_d    = 16'd0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q    <= IDLE;
            bram_q     <= '0;
            log_ack_q  <= 1'b0;
            rd_ack_q   <= 1'b0;
            rd_dat_q   <= 16'd0;
            wr_ptr_q   <= 12'd0;
            count_q    <= 13'd0;
            drop_q     <= 16'd0;
            wrapped_q  <= 1'b0;
            err_q      <= 1'b0;
            last_wr_q  <= 1'b0;
            tmo_q      <= 8'd0;
            clr_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bram_q     <= bram_d;
            log_ack_q  <= log_ack_d;
            rd_ack_q   <= rd_ack_d;
            rd_dat_q   <= rd_dat_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
            wrapped_q  <= wrapped_d;
            err_q      <= err_d;
            last_wr_q  <= last_wr_d;
            tmo_q      <= tmo_d;
            clr_seen_q <= clr_seen_d;
        end
    end

    assign bram_wb_cyc_o = bram_q.cyc;
    assign bram_wb_stb_o = bram_q.stb;
    assign bram_wb_we_o  = bram_q.we;
    assign bram_wb_adr_o = bram_q.adr;
    assign bram_wb_dat_o = bram_q.dat;
    assign log_ack_o     = log_ack_q;
    assign rd_wb_ack_o   = rd_ack_q;
    assign rd_wb_dat_o   = rd_dat_q;
    assign wr_ptr_o      = wr_ptr_q;
    assign count_o       = count_q;
    assign drop_cnt_o    = drop_q;
    assign wrapped_o     = wrapped_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_logging_bram_arbiter.sv
// Two arbiters (DEPTH=4, TIMEOUT=8): instance 0 overwrites as a ring, instance 1 stops on full.
// Instance 0 bus beats and read data are checked against a queue of expected results.
module tb_logging_bram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        log_en [2], clr [2], log_req [2], log_ack [2];
    logic [15:0] log_dat [2];
    logic        rd_cyc [2], rd_stb [2], rd_ack [2];
    logic [11:0] rd_adr [2];
    logic [15:0] rd_dat [2];
    logic        b_cyc [2], b_stb [2], b_we [2], b_ack [2], stall [2];
    logic [11:0] b_adr [2];
    logic [15:0] b_dato [2], b_dati [2];
    logic [11:0] wr_ptr [2];
    logic [12:0] count [2];
    logic [15:0] drop [2];
    logic        wrapped [2], err [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [15:0] mem [16];
        int beats;

        logging_bram_arbiter #(.DEPTH(4), .STOP_ON_FULL(g == 1), .TIMEOUT(8)) u_dut (
            .wb_clk_i(clk), .wb_rst_n_i(rst_n), .log_en_i(log_en[g]), .clr_i(clr[g]),
            .log_req_i(log_req[g]), .log_dat_i(log_dat[g]), .log_ack_o(log_ack[g]),
            .rd_wb_cyc_i(rd_cyc[g]), .rd_wb_stb_i(rd_stb[g]), .rd_wb_adr_i(rd_adr[g]),
            .rd_wb_dat_o(rd_dat[g]), .rd_wb_ack_o(rd_ack[g]),
            .bram_wb_cyc_o(b_cyc[g]), .bram_wb_stb_o(b_stb[g]), .bram_wb_we_o(b_we[g]),
            .bram_wb_adr_o(b_adr[g]), .bram_wb_dat_o(b_dato[g]), .bram_wb_dat_i(b_dati[g]),
            .bram_wb_ack_i(b_ack[g]), .wr_ptr_o(wr_ptr[g]), .count_o(count[g]),
            .drop_cnt_o(drop[g]), .wrapped_o(wrapped[g]), .err_o(err[g])
        );

        // Zero-wait blockram unless stalled.
        assign b_ack[g]  = b_cyc[g] && b_stb[g] && !stall[g];
        assign b_dati[g] = mem[b_adr[g][3:0]];
        always @(posedge clk) if (b_ack[g] && b_we[g]) mem[b_adr[g][3:0]] <= b_dato[g];
        always @(posedge clk or negedge rst_n)
            if (!rst_n) beats <= 0;
            else if (b_ack[g]) beats <= beats + 1;
    end

    typedef struct packed {
        logic        we;
        logic [11:0] adr;
        logic [15:0] dat;
    } beat_t;

    beat_t       bus_q [$];
    logic [15:0] rdat_q [$];
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_bram"}, 32'({b_cyc[0], b_stb[0], b_we[0], b_adr[0], b_dato[0]}), 0);
        chk({tag, "_acks"}, 32'({log_ack[0], rd_ack[0], rd_dat[0]}), 0);
        chk({tag, "_ptr_cnt"}, 32'({wr_ptr[0], count[0]}), 0);
        chk({tag, "_drop_flags"}, 32'({drop[0], wrapped[0], err[0]}), 0);
    endtask

    // Each transaction starts in a fresh cycle; lat counts edges from request to ack.
    task automatic do_write(input int d, input logic [15:0] dat, output int lat);
        @(posedge clk); #1;
        log_req[d] = 1'b1;
        log_dat[d] = dat;
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            lat++;
            if (log_ack[d]) break;
        end
        chk("write_ack_seen", 32'(log_ack[d]), 1);
        log_req[d] = 1'b0;
    endtask

    task automatic do_read(input int d, input logic [11:0] adr, output int ncyc);
        @(posedge clk); #1;
        rd_cyc[d] = 1'b1;
        rd_stb[d] = 1'b1;
        rd_adr[d] = adr;
        ncyc = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (rd_ack[d]) break;
            if (b_cyc[d]) ncyc++;
        end
        chk("read_ack_seen", 32'(rd_ack[d]), 1);
        rd_cyc[d] = 1'b0;
        rd_stb[d] = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (b_cyc[0] && b_stb[0] && b_ack[0]) begin
                if (bus_q.size() == 0) chk("bus_unexpected_beat", 1, 0);
                else begin
                    beat_t e;
                    e = bus_q.pop_front();
                    chk("bus_we", 32'(b_we[0]), 32'(e.we));
                    chk("bus_adr", 32'(b_adr[0]), 32'(e.adr));
                    if (e.we) chk("bus_dat", 32'(b_dato[0]), 32'(e.dat));
                end
            end
            if (rd_ack[0]) begin
                if (rdat_q.size() == 0) chk("rd_unexpected_ack", 1, 0);
                else chk("rd_dat", 32'(rd_dat[0]), 32'(rdat_q.pop_front()));
            end
            if (log_ack[0] || rd_ack[0]) chk("ack_overlap", 32'(log_ack[0] && rd_ack[0]), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] wd [5];
        logic [3:0]  seq;
        int lat, ncyc, nack, got;
        wd = '{16'h1234, 16'h1111, 16'h2222, 16'h3333, 16'h4444};

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            log_en[d] = 1'b1; clr[d] = 1'b0; log_req[d] = 1'b0; log_dat[d] = '0;
            rd_cyc[d] = 1'b0; rd_stb[d] = 1'b0; rd_adr[d] = '0; stall[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        // Single write: request counts as cycle 1, ack high on cycle 3 (two edges later).
        bus_q.push_back('{we: 1'b1, adr: 12'd0, dat: wd[0]});
        do_write(0, wd[0], lat);
        chk("w1_latency", lat, 2);
        chk("w1_ptr", 32'(wr_ptr[0]), 1);
        chk("w1_count", 32'(count[0]), 1);
        @(posedge clk); #1;
        chk("w1_ack_one_cycle", 32'(log_ack[0]), 0);

        for (int i = 1; i < 3; i++) begin
            bus_q.push_back('{we: 1'b1, adr: 12'(i), dat: wd[i]});
            do_write(0, wd[i], lat);
        end
        chk("w3_wrapped", 32'(wrapped[0]), 0);
        chk("w3_count", 32'(count[0]), 3);
        bus_q.push_back('{we: 1'b1, adr: 12'd3, dat: wd[3]});
        do_write(0, wd[3], lat);
        chk("w4_ptr_wrap", 32'(wr_ptr[0]), 0);
        chk("w4_wrapped", 32'(wrapped[0]), 1);
        chk("w4_count", 32'(count[0]), 4);
        bus_q.push_back('{we: 1'b1, adr: 12'd0, dat: wd[4]});
        do_write(0, wd[4], lat);
        chk("w5_ptr", 32'(wr_ptr[0]), 1);
        chk("w5_count_sat", 32'(count[0]), 4);
        chk("w5_wrapped", 32'(wrapped[0]), 1);

        // Stop-on-full instance: fifth write is dropped without a bram cycle.
        for (int i = 0; i < 4; i++) do_write(1, wd[i], lat);
        chk("sof_count", 32'(count[1]), 4);
        do_write(1, wd[4], lat);
        chk("sof_drop_latency", lat, 1);
        chk("sof_drop_cnt", 32'(drop[1]), 1);
        chk("sof_ptr", 32'(wr_ptr[1]), 0);
        chk("sof_count_held", 32'(count[1]), 4);
        chk("sof_beats", g_dut[1].beats, 4);

        // Both held; write was served last, so reads go first and grants alternate.
        bus_q.push_back('{we: 1'b0, adr: 12'd3, dat: 16'h0});
        bus_q.push_back('{we: 1'b1, adr: 12'd1, dat: 16'hBEEF});
        bus_q.push_back('{we: 1'b0, adr: 12'd3, dat: 16'h0});
        bus_q.push_back('{we: 1'b1, adr: 12'd2, dat: 16'hBEEF});
        rdat_q.push_back(wd[3]);
        rdat_q.push_back(wd[3]);
        @(posedge clk); #1;
        log_req[0] = 1'b1; log_dat[0] = 16'hBEEF;
        rd_cyc[0] = 1'b1; rd_stb[0] = 1'b1; rd_adr[0] = 12'd3;
        seq = '0;
        nack = 0;
        for (int i = 0; i < 40 && nack < 4; i++) begin
            @(posedge clk); #1;
            if (log_ack[0] || rd_ack[0]) begin
                seq = {seq[2:0], log_ack[0]};
                nack++;
            end
        end
        log_req[0] = 1'b0; rd_cyc[0] = 1'b0; rd_stb[0] = 1'b0;
        chk("rr_acks", nack, 4);
        chk("rr_order_RWRW", 32'(seq), 32'(4'b0101));
        chk("rr_ptr", 32'(wr_ptr[0]), 3);

        // Bram never acks: read and write both time out after 8 cycles.
        stall[0] = 1'b1;
        rdat_q.push_back(16'hDEAD);
        do_read(0, 12'd5, ncyc);
        chk("tmo_rd_cyc_cycles", ncyc, 8);
        chk("tmo_rd_cyc_low", 32'(b_cyc[0]), 0);
        chk("tmo_rd_err", 32'(err[0]), 1);
        do_write(0, 16'h5555, lat);
        chk("tmo_wr_latency", lat, 9);
        chk("tmo_wr_drop", 32'(drop[0]), 1);
        chk("tmo_wr_ptr_held", 32'(wr_ptr[0]), 3);
        chk("tmo_wr_count_held", 32'(count[0]), 4);
        stall[0] = 1'b0;
        @(posedge clk); #1;
        clr[0] = 1'b1;
        @(posedge clk); #1;
        clr[0] = 1'b0;
        chk("clr_err", 32'(err[0]), 0);
        chk("clr_drop", 32'(drop[0]), 0);
        chk("clr_ptr_cnt", 32'({wr_ptr[0], count[0]}), 0);
        chk("clr_wrapped", 32'(wrapped[0]), 0);

        // Clear and enable drop while a write waits: it completes, pointer stays 0.
        @(posedge clk); #1;
        stall[0] = 1'b1;
        log_req[0] = 1'b1; log_dat[0] = 16'hC1C1;
        bus_q.push_back('{we: 1'b1, adr: 12'd0, dat: 16'hC1C1});
        @(posedge clk); #1;
        chk("clrwr_in_wr", 32'(b_cyc[0]), 1);
        log_en[0] = 1'b0;
        clr[0] = 1'b1;
        @(posedge clk); #1;
        clr[0] = 1'b0;
        stall[0] = 1'b0;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (log_ack[0]) begin
                got = 1;
                break;
            end
        end
        log_req[0] = 1'b0;
        log_en[0] = 1'b1;
        chk("clrwr_ack", got, 1);
        chk("clrwr_ptr", 32'(wr_ptr[0]), 0);
        chk("clrwr_count", 32'(count[0]), 0);

        // Reset during a stalled write: outputs clear at once, no late ack.
        bus_q.push_back('{we: 1'b1, adr: 12'd0, dat: 16'h6666});
        do_write(0, 16'h6666, lat);
        chk("pre_rst_ptr", 32'(wr_ptr[0]), 1);
        @(posedge clk); #1;
        stall[0] = 1'b1;
        log_req[0] = 1'b1; log_dat[0] = 16'h7777;
        @(posedge clk); #1;
        chk("rst_in_wr", 32'(b_cyc[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        log_req[0] = 1'b0;
        stall[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        got = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (log_ack[0] || b_cyc[0]) got++;
        end
        chk("post_rst_no_ack", got, 0);

        chk("bus_q_empty", bus_q.size(), 0);
        chk("rdat_q_empty", rdat_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/logging_bram_arbiter.md
LOGGING_BRAM_ARBITER -- requirements
Module: logging_bram_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2048: logging blockram depth in 16-bit words; supported range 2..4096.
REQ-002 SHALL have parameter STOP_ON_FULL, default 0: 0 = ring buffer overwrite; 1 = drop writes once full.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum cycles spent waiting for bram ack, range 1..255.
REQ-004 SHALL have port wb_clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port wb_rst_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port log_en_i, input, 1 bit: logging enable; 0 = write requests are not granted.
REQ-007 SHALL have port clr_i, input, 1 bit: synchronous clear of pointer, count and status.
REQ-008 SHALL have ports log_req_i (input, 1 bit), log_dat_i (input, 16 bits) and log_ack_o (output, 1 bit): logger write handshake.
REQ-009 SHALL have ports rd_wb_cyc_i, rd_wb_stb_i (inputs, 1 bit each), rd_wb_adr_i (input, 12 bits), rd_wb_dat_o (output, 16 bits) and rd_wb_ack_o (output, 1 bit): memory-window read slave.
REQ-010 SHALL have ports bram_wb_cyc_o, bram_wb_stb_o, bram_wb_we_o (outputs, 1 bit each), bram_wb_adr_o (output, 12 bits), bram_wb_dat_o (output, 16 bits), bram_wb_dat_i (input, 16 bits) and bram_wb_ack_i (input, 1 bit): blockram master.
REQ-011 SHALL have ports wr_ptr_o (output, 12 bits), count_o (output, 13 bits), drop_cnt_o (output, 16 bits), wrapped_o (output, 1 bit) and err_o (output, 1 bit): status.

Function
REQ-012 SHALL register all outputs.
REQ-013 SHALL implement FSM states IDLE, WR and RD.
REQ-014 Requests: write pending = log_req_i && log_en_i; read pending = rd_wb_cyc_i && rd_wb_stb_i.
REQ-015 In IDLE, SHALL NOT grant a requester whose ack output is high in the same cycle.
REQ-016 Arbitration in IDLE: a single pending request is granted; if both are pending, the requester not served last is granted (round-robin); last-served resets to read.
REQ-017 Write grant: latch log_dat_i; next cycle state = WR with bram cyc=stb=we=1, adr=wr_ptr_o, dat=latched data.
REQ-018 Read grant: latch rd_wb_adr_i[11:0]; next cycle state = RD with cyc=stb=1, we=0, adr=latched address.
REQ-019 On bram_wb_ack_i in WR: next cycle cyc=stb=we=0, log_ack_o=1 for exactly one cycle, state -> IDLE.
REQ-020 On bram_wb_ack_i in WR, pointer update: wr_ptr_o increments, wrapping DEPTH-1 -> 0; wrap sets wrapped_o (sticky); count_o increments, saturating at DEPTH.
REQ-021 On bram_wb_ack_i in RD: next cycle rd_wb_dat_o = bram_wb_dat_i captured at the ack, rd_wb_ack_o=1 for one cycle, cyc=stb=0, state -> IDLE.
REQ-022 rd_wb_dat_o SHALL hold its value between acks.
REQ-023 Minimum latency, request to requester ack: 3 cycles (grant, bram access with zero-wait ack, ack).
REQ-024 STOP_ON_FULL=1 and count_o==DEPTH: a write request is acked from IDLE on the next cycle with no bram access; drop_cnt_o increments, saturating at 16'hFFFF.
REQ-025 Timeout: a cycle counter starts at WR/RD entry. If no ack arrives within TIMEOUT cycles: cyc=stb=0; requester acked anyway (read data 16'hDEAD); err_o set (sticky); write counted as dropped; pointer unchanged; state -> IDLE.
REQ-026 clr_i=1: wr_ptr_o=0, count_o=0, wrapped_o=0, err_o=0, drop_cnt_o=0 next cycle.
REQ-027 clr_i takes priority over a same-cycle increment.
REQ-028 clr_i does not abort an in-flight transaction; the transaction completes normally with its pointer increment suppressed.
REQ-029 log_en_i falling during WR SHALL NOT abort that write.
REQ-030 Writes SHALL never target addresses >= DEPTH; bram_wb_adr_o bits above log2(DEPTH) are 0 during writes.

Reset
REQ-031 wb_rst_n_i low SHALL asynchronously force: state IDLE; all bram outputs 0; log_ack_o=0; rd_wb_ack_o=0; rd_wb_dat_o=0; wr_ptr_o=0; count_o=0; drop_cnt_o=0; wrapped_o=0; err_o=0; last-served = read; timeout counter = 0.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction; no ack is issued after reset release.

Verification
REQ-033 Single write: log_en_i=1, write 16'h1234 with zero-wait bram -> bram_wb_adr_o=0, we=1; log_ack_o on cycle 3; wr_ptr_o=1, count_o=1.
REQ-034 Simultaneous requests, both held for 4 transactions -> grants alternate R, W, R, W; no cycle has both acks high.
REQ-035 DEPTH=4, STOP_ON_FULL=0, 5 writes -> 5th write to address 0; wrapped_o=1; count_o=4. Same bench with STOP_ON_FULL=1 -> 5th write acked without bram cycle; drop_cnt_o=1.
REQ-036 Read request, bram never acks, TIMEOUT=8 -> cyc drops after 8 cycles; rd_wb_ack_o pulses with 16'hDEAD; err_o=1; clr_i then clears err_o.
REQ-037 Reset asserted in WR -> all outputs 0 immediately (asynchronous); no log_ack_o after release.
REQ-038 clr_i pulsed while WR awaits ack -> write completes, log_ack_o pulses, wr_ptr_o=0 afterwards.
